// File: rtl/mcu_bus_pkg.sv
// Shared bus definitions for the MCU memory subsystem.
// Provides FSM state encodings for the memory bus master, default address/data
// widths, the burst-length field width, the read-latency counter width, and the
// port I/O window base addresses. MEMORY and the control unit use the same
// memory-map constants.
package mcu_bus_pkg;

  localparam int unsigned AW_DEF = 8;  // default address width
  localparam int unsigned DW_DEF = 8;  // default data width
  localparam int unsigned LEN_W  = 4;  // burst length field, beats minus one
  localparam int unsigned LAT_W  = 2;  // read latency counter, supports 1..3

  // Memory map: port I/O windows at the top of the address space.
  localparam logic [7:0] IO_IN_BASE  = 8'hF0;
  localparam logic [7:0] IO_OUT_BASE = 8'hF8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_HOLD  = 3'd4
  } bus_state_e;

endpackage

// File: rtl/mem_bus_master.sv
// mem_bus_master: sole owner of the MEMORY bus.
// Converts one read/write burst command (1-16 beats) into cycle-exact memory
// accesses. Write beats stream in over WR_VALID/WR_READY, and read beats stream
// out over RD_VALID/RD_READY.
// Ports:
//   CLK, RST                                  clock, synchronous active-high reset
//   CMD_VALID/READY, CMD_WRITE/ADDR/LEN       command handshake and payload
//   WR_VALID/READY, WR_DATA                   write beat stream
//   RD_VALID/READY, RD_DATA                   read beat stream (registered)
//   MEM_ADDRESS, MEM_DIN, MEM_EN_WRITE        registered memory pins
//   MEM_DOUT                                  memory read data
//   BUSY, DONE                                status; DONE pulses once per burst
module mem_bus_master
  import mcu_bus_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_WRITE,
  input  logic [AW-1:0]    CMD_ADDR,
  input  logic [LEN_W-1:0] CMD_LEN,
  input  logic             WR_VALID,
  output logic             WR_READY,
  input  logic [DW-1:0]    WR_DATA,
  output logic             RD_VALID,
  input  logic             RD_READY,
  output logic [DW-1:0]    RD_DATA,
  output logic [AW-1:0]    MEM_ADDRESS,
  output logic [DW-1:0]    MEM_DIN,
  output logic             MEM_EN_WRITE,
  input  logic [DW-1:0]    MEM_DOUT,
  output logic             BUSY,
  output logic             DONE
);

  bus_state_e       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [LAT_W-1:0] wait_q, wait_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_din_q, mem_din_d;
  logic             mem_we_q, mem_we_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             done_q, done_d;

  // Handshake readiness decoded from the registered state.
  // WRITE is left on the last beat, so beats always remain while in WRITE.
  assign CMD_READY    = (state_q == ST_IDLE);
  assign WR_READY     = (state_q == ST_WRITE);
  assign BUSY         = (state_q != ST_IDLE);
  assign MEM_ADDRESS  = mem_addr_q;
  assign MEM_DIN      = mem_din_q;
  assign MEM_EN_WRITE = mem_we_q;
  assign RD_DATA      = rd_data_q;
  assign RD_VALID     = rd_valid_q;
  assign DONE         = done_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    wait_d     = wait_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          addr_d  = CMD_ADDR;
          beats_d = CMD_LEN;
          state_d = CMD_WRITE ? ST_WRITE : ST_RD_ISSUE;
        end
      end
      ST_WRITE: begin
        if (WR_VALID) begin
          mem_addr_d = addr_q;
          mem_din_d  = WR_DATA;
          mem_we_d   = 1'b1;
          addr_d     = addr_q + AW'(1);
          if (beats_q == '0) begin
            // DONE lines up with the final write enable.
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            beats_d = beats_q - LEN_W'(1);
          end
        end
      end
      ST_RD_ISSUE: begin
        mem_addr_d = addr_q;
        wait_d     = LAT_W'(RD_LATENCY);
        state_d    = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // Capture on the edge where the count reaches zero. That is RD_LATENCY
        // edges after MEM_ADDRESS was loaded.
        wait_d = wait_q - LAT_W'(1);
        if (wait_q == LAT_W'(1)) begin
          rd_data_d  = MEM_DOUT;
          rd_valid_d = 1'b1;
          state_d    = ST_RD_HOLD;
        end
      end
      ST_RD_HOLD: begin
        if (RD_READY) begin
          rd_valid_d = 1'b0;
          addr_d     = addr_q + AW'(1);
          if (beats_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            beats_d = beats_q - LEN_W'(1);
            state_d = ST_RD_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      wait_q     <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      wait_q     <= wait_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed testbench for mem_bus_master with RD_LATENCY = 1.
// Includes a behavioural MEMORY that writes synchronously and reads the
// registered MEM_ADDRESS combinationally.
module tb_mem_bus_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic [7:0] mem_address, mem_din, mem_dout;
  logic       mem_en_write;
  logic       busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en_write) mem[mem_address] <= mem_din;
  end
  assign mem_dout = mem[mem_address];

  mem_bus_master #(.RD_LATENCY(1), .AW(8), .DW(8)) dut (
    .CLK          (clk),
    .RST          (rst),
    .CMD_VALID    (cmd_valid),
    .CMD_READY    (cmd_ready),
    .CMD_WRITE    (cmd_write),
    .CMD_ADDR     (cmd_addr),
    .CMD_LEN      (cmd_len),
    .WR_VALID     (wr_valid),
    .WR_READY     (wr_ready),
    .WR_DATA      (wr_data),
    .RD_VALID     (rd_valid),
    .RD_READY     (rd_ready),
    .RD_DATA      (rd_data),
    .MEM_ADDRESS  (mem_address),
    .MEM_DIN      (mem_din),
    .MEM_EN_WRITE (mem_en_write),
    .MEM_DOUT     (mem_dout),
    .BUSY         (busy),
    .DONE         (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Back-to-back write burst; WR_VALID is already high while the command is in IDLE.
  task automatic wr_burst(input logic [7:0] a, input logic [3:0] len, input logic [7:0] d0);
    logic [7:0] ea;
    chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len;
    wr_valid = 1'b1; wr_data = d0;
    tick;
    cmd_valid = 1'b0;
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_ready", 32'(wr_ready), 32'd1);
    chk("wr_idle_no_en", 32'(mem_en_write), 32'd0);
    for (int b = 0; b <= int'(len); b++) begin
      wr_data = d0 + 8'(b);
      tick;
      ea = a + 8'(b);
      chk("wr_en", 32'(mem_en_write), 32'd1);
      chk("wr_addr", 32'(mem_address), 32'(ea));
      chk("wr_din", 32'(mem_din), 32'(wr_data));
      chk("wr_done", 32'(done), 32'(b == int'(len)));
    end
    wr_valid = 1'b0;
    tick;
    chk("wr_end_en", 32'(mem_en_write), 32'd0);
    chk("wr_end_done", 32'(done), 32'd0);
    chk("wr_end_busy", 32'(busy), 32'd0);
  endtask

  // Read burst; stall_beat >= 0 holds RD_READY low for 5 cycles on that beat.
  task automatic rd_burst(input logic [7:0] a, input logic [3:0] len, input logic [7:0] exp0,
                          input int stall_beat);
    logic [7:0] ea;
    logic [7:0] ed;
    chk("rd_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len; rd_ready = 1'b1;
    tick;
    cmd_valid = 1'b0;
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_wr_ready", 32'(wr_ready), 32'd0);
    for (int b = 0; b <= int'(len); b++) begin
      ea = a + 8'(b);
      ed = exp0 + 8'(b);
      tick;
      chk("rd_addr", 32'(mem_address), 32'(ea));
      chk("rd_no_en", 32'(mem_en_write), 32'd0);
      chk("rd_not_valid", 32'(rd_valid), 32'd0);
      tick;
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_data", 32'(rd_data), 32'(ed));
      if (b == stall_beat) begin
        rd_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick;
          chk("stall_valid", 32'(rd_valid), 32'd1);
          chk("stall_data", 32'(rd_data), 32'(ed));
          chk("stall_addr", 32'(mem_address), 32'(ea));
        end
        rd_ready = 1'b1;
      end
      tick;
      chk("rd_hs_valid", 32'(rd_valid), 32'd0);
      chk("rd_done", 32'(done), 32'(b == int'(len)));
      chk("rd_hs_no_en", 32'(mem_en_write), 32'd0);
    end
    tick;
    chk("rd_end_done", 32'(done), 32'd0);
    chk("rd_end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    tick; tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_en", 32'(mem_en_write), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_din", 32'(mem_din), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick;

    // Write burst at 0x10, followed by read-back with RD_READY tied high
    wr_burst(8'h10, 4'd3, 8'hA0);
    chk("mem10", 32'(mem[8'h10]), 32'hA0);
    chk("mem11", 32'(mem[8'h11]), 32'hA1);
    chk("mem12", 32'(mem[8'h12]), 32'hA2);
    chk("mem13", 32'(mem[8'h13]), 32'hA3);
    rd_burst(8'h10, 4'd3, 8'hA0, -1);

    // Address wrap inside a burst
    wr_burst(8'hFE, 4'd3, 8'h50);
    chk("memFE", 32'(mem[8'hFE]), 32'h50);
    chk("mem01", 32'(mem[8'h01]), 32'h53);
    rd_burst(8'hFE, 4'd3, 8'h50, -1);

    // Consumer back-pressure on the second beat
    rd_burst(8'h10, 4'd3, 8'hA0, 1);

    // Write with WR_VALID gaps while a second command waits upstream
    begin
      logic [6:0] pat;
      logic [7:0] ea;
      int k;
      pat = 7'b1101001;
      k = 0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_len = 4'd3;
      tick;
      cmd_write = 1'b0; cmd_addr = 8'h99; cmd_len = 4'd0;
      for (int c = 0; c < 7; c++) begin
        wr_valid = pat[c];
        wr_data = 8'hC0 + 8'(k);
        cmd_valid = (c < 6);
        tick;
        chk("gap_en", 32'(mem_en_write), 32'(pat[c]));
        if (pat[c]) begin
          ea = 8'h20 + 8'(k);
          chk("gap_addr", 32'(mem_address), 32'(ea));
          chk("gap_din", 32'(mem_din), 32'(wr_data));
          k++;
        end
        chk("gap_cmd_ready", 32'(cmd_ready), 32'(c == 6));
        chk("gap_done", 32'(done), 32'(c == 6));
      end
      wr_valid = 1'b0;
      tick;
      chk("gap_end_en", 32'(mem_en_write), 32'd0);
      chk("gap_end_busy", 32'(busy), 32'd0);
      chk("mem20", 32'(mem[8'h20]), 32'hC0);
      chk("mem21", 32'(mem[8'h21]), 32'hC1);
      chk("mem22", 32'(mem[8'h22]), 32'hC2);
      chk("mem23", 32'(mem[8'h23]), 32'hC3);
    end

    // Reset aborts an 8-beat write after 2 beats
    wr_burst(8'h30, 4'd7, 8'h80);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_len = 4'd7;
    wr_valid = 1'b1; wr_data = 8'hE0;
    tick;
    cmd_valid = 1'b0;
    tick;
    chk("abort_b0_en", 32'(mem_en_write), 32'd1);
    wr_data = 8'hE1;
    tick;
    chk("abort_b1_addr", 32'(mem_address), 32'h31);
    rst = 1'b1;
    tick;
    rst = 1'b0; wr_valid = 1'b0;
    chk("abort_en", 32'(mem_en_write), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_mem30", 32'(mem[8'h30]), 32'hE0);
    chk("abort_mem31", 32'(mem[8'h31]), 32'hE1);
    chk("abort_mem32", 32'(mem[8'h32]), 32'h82);
    chk("abort_mem37", 32'(mem[8'h37]), 32'h87);
    rd_burst(8'h30, 4'd0, 8'hE0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
